// File: rtl/spm_pkg.sv
// Shared scratchpad definitions: off_chip_bus field layout, bank count and
// the loader FSM state type.
package spm_pkg;

  localparam int unsigned BUS_W         = 44;
  localparam int unsigned ACCESS_EN_BIT = 43;
  localparam int unsigned WR_SEL_BIT    = 42;
  localparam int unsigned BANK_LSB      = 40;
  localparam int unsigned ADDR_LSB      = 32;
  localparam int unsigned NUM_BANKS     = 4;
  localparam int unsigned BANK_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } ldr_state_e;

endpackage

// File: rtl/offchip_out_reg.sv
// One-entry output register holding a pending bank write until the sink
// accepts it; a load in the draining cycle refills it back-to-back.
module offchip_out_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              sink_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic              drain,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    drain   = valid_q && sink_ready;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (drain) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = in_addr;
      data_d  = in_data;
    end
    if (clear) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign data  = data_q;

endmodule

// File: rtl/offchip_loader.sv
// Burst loader: streams off-chip words into sequential scratchpad bank
// writes on off_chip_bus, yielding to LSU traffic via bank_busy.
module offchip_loader
  import spm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_start,
  input  logic [BANK_W-1:0]    cmd_bank,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 src_valid,
  input  logic [DATA_W-1:0]    src_data,
  output logic                 src_ready,
  input  logic [NUM_BANKS-1:0] bank_busy,
  output logic [BUS_W-1:0]     off_chip_bus,
  output logic                 busy,
  output logic                 done,
  input  logic                 abort
);

  ldr_state_e        state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              done_q, done_d;

  logic              out_valid, drain, sink_ready, hs;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  assign sink_ready = !bank_busy[bank_q];

  // Taking a new word is allowed when the register is empty or empties this cycle.
  always_comb begin
    src_ready = (state_q == ST_BURST) && (rem_q != '0) &&
                (!out_valid || drain) && !abort;
  end

  assign hs = src_valid && src_ready;

  offchip_out_reg #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst),
    .load       (hs),
    .clear      (abort),
    .sink_ready (sink_ready),
    .in_addr    (addr_q),
    .in_data    (src_data),
    .valid      (out_valid),
    .drain      (drain),
    .addr       (out_addr),
    .data       (out_data)
  );

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_start) begin
            bank_d = cmd_bank;
            addr_d = cmd_addr;
            rem_d  = cmd_len;
            if (cmd_len == '0) done_d  = 1'b1;
            else               state_d = ST_BURST;
          end
        end
        ST_BURST: begin
          if (hs) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!out_valid || drain) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // The bus idles at all-zero when no write is pending.
  always_comb begin
    off_chip_bus = '0;
    if (out_valid) begin
      off_chip_bus[ACCESS_EN_BIT]          = drain;
      off_chip_bus[WR_SEL_BIT]             = 1'b1;
      off_chip_bus[BANK_LSB +: BANK_W]     = bank_q;
      off_chip_bus[ADDR_LSB +: ADDR_W]     = out_addr;
      off_chip_bus[DATA_W-1:0]             = out_data;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_offchip_loader.sv
// Bench for offchip_loader: directed burst table, hand sequences for
// abort/reset/ignored start, and randomized traffic against a queue model.
module tb_offchip_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [1:0]  cmd_bank;
  logic [7:0]  cmd_addr;
  logic [8:0]  cmd_len;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic [3:0]  bank_busy;
  logic [43:0] off_chip_bus;
  logic        busy;
  logic        done;
  logic        abort;

  always #5 clk = ~clk;

  offchip_loader #(
    .DATA_W(32),
    .ADDR_W(8),
    .LEN_W (9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_start    (cmd_start),
    .cmd_bank     (cmd_bank),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .bank_busy    (bank_busy),
    .off_chip_bus (off_chip_bus),
    .busy         (busy),
    .done         (done),
    .abort        (abort)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a command in flight, its next address, words still to
  // fetch, and the accepted-but-unwritten words in order.
  typedef struct {
    int          addr;
    logic [31:0] data;
  } beat_t;
  beat_t pend[$];
  bit m_active, m_done;
  int m_bank, m_addr, m_rem;

  int          accepted, wr_count, done_count, last_addr, last_bank;
  logic [31:0] last_data;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic clear_inputs();
    cmd_start = 0; cmd_bank = 0; cmd_addr = 0; cmd_len = 0;
    src_valid = 0; src_data = 0; bank_busy = 0; abort = 0;
  endtask

  task automatic clear_obs();
    accepted = 0; wr_count = 0; done_count = 0;
    last_addr = -1; last_bank = -1; last_data = '0;
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_rem = 0; m_addr = 0; m_bank = 0;
    pend.delete();
  endtask

  // Called just after a falling edge with inputs set; checks outputs, then
  // advances the model across the rising edge.
  task automatic cycle();
    logic [43:0] eb;
    bit acc, rdy, hs, nd;
    #1;
    acc = (pend.size() > 0) && !bank_busy[m_bank];
    rdy = !abort && m_active && (m_rem > 0) && (pend.size() == 0 || acc);
    eb  = '0;
    if (pend.size() > 0)
      eb = {acc, 1'b1, 2'(m_bank), 8'(pend[0].addr), pend[0].data};
    chk("src_ready", {63'd0, src_ready}, {63'd0, rdy});
    chk("busy", {63'd0, busy}, {63'd0, m_active});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("bus", {20'd0, off_chip_bus}, {20'd0, eb});
    if (off_chip_bus[43]) begin
      wr_count++;
      last_addr = int'(off_chip_bus[39:32]);
      last_bank = int'(off_chip_bus[41:40]);
      last_data = off_chip_bus[31:0];
    end
    if (done) done_count++;
    @(posedge clk);
    hs = src_valid && rdy;
    nd = 0;
    if (abort) begin
      m_active = 0;
      pend.delete();
    end else if (!m_active) begin
      if (cmd_start) begin
        if (cmd_len == 0) nd = 1;
        else begin
          m_active = 1; m_bank = int'(cmd_bank);
          m_addr = int'(cmd_addr); m_rem = int'(cmd_len);
        end
      end
    end else begin
      if (acc) void'(pend.pop_front());
      if (hs) begin
        pend.push_back('{m_addr, src_data});
        m_addr = (m_addr + 1) % 256;
        m_rem--;
        accepted++;
      end
      if (m_rem == 0 && pend.size() == 0) begin
        m_active = 0;
        nd = 1;
      end
    end
    m_done = nd;
    @(negedge clk);
  endtask

  task automatic issue(int bank, int addr, int len);
    cmd_start = 1; cmd_bank = 2'(bank); cmd_addr = 8'(addr); cmd_len = 9'(len);
    cycle();
    cmd_start = 0;
  endtask

  task automatic run_until_done(string name, int max_cycles);
    for (int k = 0; k < max_cycles && done_count == 0; k++) begin
      src_data = 32'hA + 32'(accepted);
      cycle();
    end
    chk({name, "_done_seen"}, 64'(done_count), 64'd1);
  endtask

  typedef struct {
    int          bank;
    int          addr;
    int          len;
    logic [15:0] vpat;
    logic [15:0] bpat;
    logic [3:0]  bmask;
    int          exp_writes;
    int          exp_last_addr;
    logic [31:0] exp_last_data;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 'h10, 4, 16'hFFFF, 16'h0000, 4'h0, 4, 'h13, 32'hD};
    vecs[1] = '{2, 'hFE, 4, 16'hFFFF, 16'h0000, 4'h0, 4, 'h01, 32'hD};
    vecs[2] = '{0, 'h20, 3, 16'hFFFF, 16'h003E, 4'h1, 3, 'h22, 32'hC};
    vecs[3] = '{0, 'h30, 3, 16'hFFFF, 16'h000E, 4'h2, 3, 'h32, 32'hC};
    vecs[4] = '{3, 'h40, 3, 16'hFFF9, 16'h0000, 4'h0, 3, 'h42, 32'hC};
    vecs[5] = '{1, 'h70, 0, 16'hFFFF, 16'h0000, 4'h0, 0, -1,   32'h0};

    clear_inputs();
    model_reset();
    rst = 0;
    #1;
    chk("rst_bus", {20'd0, off_chip_bus}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, src_ready}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1;

    // Directed burst table
    for (int i = 0; i < 6; i++) begin
      clear_obs();
      issue(vecs[i].bank, vecs[i].addr, vecs[i].len);
      for (int k = 0; k < 80 && done_count == 0; k++) begin
        src_valid = (k < 16) ? vecs[i].vpat[k] : 1'b1;
        bank_busy = (k < 16 && vecs[i].bpat[k]) ? vecs[i].bmask : 4'h0;
        src_data  = 32'hA + 32'(accepted);
        cycle();
      end
      clear_inputs();
      chk($sformatf("v%0d_done_seen", i), 64'(done_count), 64'd1);
      chk($sformatf("v%0d_writes", i), 64'(wr_count), 64'(vecs[i].exp_writes));
      if (vecs[i].exp_writes > 0) begin
        chk($sformatf("v%0d_last_addr", i), 64'(last_addr), 64'(vecs[i].exp_last_addr));
        chk($sformatf("v%0d_last_bank", i), 64'(last_bank), 64'(vecs[i].bank));
        chk($sformatf("v%0d_last_data", i), {32'd0, last_data}, {32'd0, vecs[i].exp_last_data});
      end
      cycle();
    end

    // Second command mid-burst is ignored
    clear_obs();
    src_valid = 1;
    issue(1, 'h40, 4);
    src_data = 32'hA + 32'(accepted);
    cycle();
    cmd_start = 1; cmd_bank = 2; cmd_addr = 8'h80; cmd_len = 9'd2;
    src_data = 32'hA + 32'(accepted);
    cycle();
    cmd_start = 0;
    run_until_done("ignore", 40);
    chk("ignore_writes", 64'(wr_count), 64'd4);
    chk("ignore_last_addr", 64'(last_addr), 64'h43);
    chk("ignore_last_bank", 64'(last_bank), 64'd1);
    clear_inputs();
    cycle();

    // Abort after two writes
    clear_obs();
    src_valid = 1;
    issue(3, 'h50, 5);
    for (int k = 0; k < 20 && wr_count < 2; k++) begin
      src_data = 32'hA + 32'(accepted);
      cycle();
    end
    chk("abort_two_writes", 64'(wr_count), 64'd2);
    abort = 1;
    cycle();
    abort = 0;
    begin
      int n;
      n = wr_count;
      repeat (10) begin
        src_data = 32'hA + 32'(accepted);
        cycle();
      end
      chk("abort_no_more_writes", 64'(wr_count), 64'(n));
    end
    chk("abort_no_done", 64'(done_count), 64'd0);
    chk("abort_idle", {63'd0, busy}, 64'd0);

    // Abort and start together: command dropped
    abort = 1; cmd_start = 1; cmd_bank = 1; cmd_addr = 8'h11; cmd_len = 9'd3;
    cycle();
    clear_inputs();
    cycle();
    chk("abort_start_dropped", {63'd0, busy}, 64'd0);

    // Reset mid-burst, then a clean burst
    clear_obs();
    src_valid = 1;
    issue(1, 'h60, 6);
    repeat (3) begin
      src_data = 32'hA + 32'(accepted);
      cycle();
    end
    #3;
    rst = 0;
    #1;
    chk("rst_mid_bus", {20'd0, off_chip_bus}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_ready", {63'd0, src_ready}, 64'd0);
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst = 1;
    clear_obs();
    src_valid = 1;
    issue(2, 'h08, 3);
    run_until_done("post_rst", 40);
    chk("post_rst_writes", 64'(wr_count), 64'd3);
    chk("post_rst_last_addr", 64'(last_addr), 64'h0A);
    chk("post_rst_last_data", {32'd0, last_data}, 64'hC);
    clear_inputs();
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 40; c++) begin
      clear_obs();
      src_valid = 1'($urandom_range(0, 1));
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 12)));
      for (int k = 0; k < 300; k++) begin
        src_valid = ($urandom_range(0, 3) != 0);
        src_data  = $urandom;
        bank_busy = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        abort     = ($urandom_range(0, 60) == 0);
        cmd_start = ($urandom_range(0, 10) == 0);
        cmd_bank  = 2'($urandom_range(0, 3));
        cmd_addr  = 8'($urandom_range(0, 255));
        cmd_len   = 9'($urandom_range(0, 8));
        cycle();
        if (!m_active && k > 2) break;
      end
      clear_inputs();
      cycle();
      chk($sformatf("rand%0d_idle", c), {63'd0, busy}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
